// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi add-compare-select datapath.
package viterbi_pkg;

    localparam int unsigned PM_WIDTH_DEFAULT = 12;
    localparam int unsigned MAX_STATES       = 64;

    localparam logic signed [PM_WIDTH_DEFAULT-1:0] PM_INIT =
        {2'b11, {(PM_WIDTH_DEFAULT-2){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } acs_state_e;

    function automatic logic [6:0] num_states(input logic [1:0] register_num);
        return 7'd64 >> register_num;
    endfunction

endpackage

// File: rtl/acs_unit_if.sv
// Branch-metric input and survivor-decision output bundle of the ACS stage.
interface acs_unit_if #(
    parameter int unsigned WIDTH_BM = 9
);
    logic signed [WIDTH_BM-1:0] bm_i;
    logic                       bm_valid_i;
    logic                       ready_o;
    logic [5:0]                 state_x_o;
    logic                       decision_o;
    logic [5:0]                 decision_state_o;
    logic                       decision_valid_o;
    logic                       step_done_o;
    logic [5:0]                 best_state_o;

    modport master (
        output bm_i, bm_valid_i,
        input  ready_o, state_x_o, decision_o, decision_state_o,
        input  decision_valid_o, step_done_o, best_state_o
    );

    modport slave (
        input  bm_i, bm_valid_i,
        output ready_o, state_x_o, decision_o, decision_state_o,
        output decision_valid_o, step_done_o, best_state_o
    );
endinterface

// File: rtl/acs_unit_acs_cell.sv
// Single butterfly half: add branch metric to both predecessors, pick the larger,
// subtract the normalisation offset and saturate to the path-metric range.
module acs_cell #(
    parameter int unsigned WIDTH_BM = 9,
    parameter int unsigned WIDTH_PM = 12
) (
    input  logic signed [WIDTH_PM-1:0] pm_lo_i,
    input  logic signed [WIDTH_PM-1:0] pm_hi_i,
    input  logic signed [WIDTH_BM-1:0] bm_i,
    input  logic signed [WIDTH_PM-1:0] offset_i,
    output logic signed [WIDTH_PM-1:0] pm_new_o,
    output logic                       decision_o
);
    localparam int unsigned WA = WIDTH_PM + 2;
    localparam logic signed [WA-1:0] SAT_MAX = {3'b000, {(WIDTH_PM-1){1'b1}}};
    localparam logic signed [WA-1:0] SAT_MIN = {3'b111, {(WIDTH_PM-1){1'b0}}};

    logic signed [WA-1:0] bm_x, lo_x, hi_x, off_x;
    logic signed [WA-1:0] c_lo, c_hi, best, norm;

    always_comb begin
        bm_x  = {{(WA-WIDTH_BM){bm_i[WIDTH_BM-1]}}, bm_i};
        lo_x  = {{2{pm_lo_i[WIDTH_PM-1]}}, pm_lo_i};
        hi_x  = {{2{pm_hi_i[WIDTH_PM-1]}}, pm_hi_i};
        off_x = {{2{offset_i[WIDTH_PM-1]}}, offset_i};

        // High-path codeword is the complement of the low one, hence -bm.
        c_lo = lo_x + bm_x;
        c_hi = hi_x - bm_x;

        decision_o = (c_hi > c_lo);
        best       = decision_o ? c_hi : c_lo;
        norm       = best - off_x;

        if (norm > SAT_MAX) begin
            pm_new_o = SAT_MAX[WIDTH_PM-1:0];
        end else if (norm < SAT_MIN) begin
            pm_new_o = SAT_MIN[WIDTH_PM-1:0];
        end else begin
            pm_new_o = norm[WIDTH_PM-1:0];
        end
    end
endmodule

// File: rtl/acs_unit.sv
// Serial add-compare-select stage: sweeps all trellis states once per step,
// keeps path metrics in a ping-pong bank and emits survivor decisions.
module acs_unit
    import viterbi_pkg::*;
#(
    parameter int unsigned WIDTH_BM = 9,
    parameter int unsigned WIDTH_PM = PM_WIDTH_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_an_i,
    input  logic       rst_sync_i,
    input  logic       frame_start_i,
    input  logic [1:0] register_num_i,
    acs_unit_if.slave  acs
);
    localparam logic signed [WIDTH_PM-1:0] PM_INIT_V = {2'b11, {(WIDTH_PM-2){1'b0}}};

    acs_state_e state_q, state_d;

    logic [5:0]                 cnt_q, cnt_d;
    logic                       bank_sel_q, bank_sel_d;
    logic signed [WIDTH_PM-1:0] offset_q, offset_d;
    logic signed [WIDTH_PM-1:0] max_q, max_d;
    logic [5:0]                 arg_q, arg_d;
    logic [1:0]                 rn_q, rn_d;
    logic                       dec_q, dec_d;
    logic [5:0]                 dec_state_q, dec_state_d;
    logic                       dec_valid_q, dec_valid_d;
    logic                       step_done_q, step_done_d;
    logic [5:0]                 best_q, best_d;

    logic signed [WIDTH_PM-1:0] bank_q [2][MAX_STATES];

    logic                       ready, init_en, accept, last;
    logic [6:0]                 n_states;
    logic [5:0]                 half, n_m1, pred_lo, pred_hi;
    logic signed [WIDTH_PM-1:0] pm_lo, pm_hi, pm_new;
    logic                       sel_hi;

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rst_sync_i) begin
            state_d = IDLE;
        end else if (frame_start_i) begin
            state_d = INIT;
        end else begin
            case (state_q)
                INIT:    state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        ready   = (state_q == RUN);
        init_en = (state_q == INIT) && !rst_sync_i && !frame_start_i;
        accept  = ready && acs.bm_valid_i && !rst_sync_i && !frame_start_i;
    end

    always_comb begin
        n_states = num_states(rn_q);
        half     = 6'(n_states >> 1);
        n_m1     = 6'(n_states - 7'd1);
        pred_lo  = {1'b0, cnt_q[5:1]};
        pred_hi  = pred_lo + half;
        last     = (cnt_q == n_m1);
        pm_lo    = bank_q[bank_sel_q][pred_lo];
        pm_hi    = bank_q[bank_sel_q][pred_hi];
    end

    acs_cell #(
        .WIDTH_BM (WIDTH_BM),
        .WIDTH_PM (WIDTH_PM)
    ) u_acs_cell (
        .pm_lo_i    (pm_lo),
        .pm_hi_i    (pm_hi),
        .bm_i       (acs.bm_i),
        .offset_i   (offset_q),
        .pm_new_o   (pm_new),
        .decision_o (sel_hi)
    );

    always_comb begin
        cnt_d       = cnt_q;
        bank_sel_d  = bank_sel_q;
        offset_d    = offset_q;
        max_d       = max_q;
        arg_d       = arg_q;
        rn_d        = rn_q;
        dec_d       = dec_q;
        dec_state_d = dec_state_q;
        dec_valid_d = 1'b0;
        step_done_d = 1'b0;
        best_d      = best_q;

        if (rst_sync_i) begin
            cnt_d       = '0;
            bank_sel_d  = 1'b0;
            offset_d    = '0;
            max_d       = '0;
            arg_d       = '0;
            rn_d        = '0;
            dec_d       = 1'b0;
            dec_state_d = '0;
            best_d      = '0;
        end else if (frame_start_i) begin
            cnt_d = '0;
        end else if (init_en) begin
            cnt_d      = '0;
            bank_sel_d = 1'b0;
            offset_d   = '0;
            rn_d       = register_num_i;
        end else if (accept) begin
            dec_d       = sel_hi;
            dec_state_d = cnt_q;
            dec_valid_d = 1'b1;
            // Final state of the step folds into max_d before it becomes the offset.
            if (cnt_q == '0 || pm_new > max_q) begin
                max_d = pm_new;
                arg_d = cnt_q;
            end
            if (last) begin
                cnt_d       = '0;
                bank_sel_d  = ~bank_sel_q;
                offset_d    = max_d;
                best_d      = arg_d;
                step_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            cnt_q       <= '0;
            bank_sel_q  <= 1'b0;
            offset_q    <= '0;
            max_q       <= '0;
            arg_q       <= '0;
            rn_q        <= '0;
            dec_q       <= 1'b0;
            dec_state_q <= '0;
            dec_valid_q <= 1'b0;
            step_done_q <= 1'b0;
            best_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            bank_sel_q  <= bank_sel_d;
            offset_q    <= offset_d;
            max_q       <= max_d;
            arg_q       <= arg_d;
            rn_q        <= rn_d;
            dec_q       <= dec_d;
            dec_state_q <= dec_state_d;
            dec_valid_q <= dec_valid_d;
            step_done_q <= step_done_d;
            best_q      <= best_d;
        end
    end

    // Writes go to the opposite bank, so the swap on the last state never races a read.
    always_ff @(posedge clk_i) begin
        if (init_en) begin
            for (int unsigned i = 0; i < MAX_STATES; i++) begin
                bank_q[0][6'(i)] <= (i == 0) ? '0 : PM_INIT_V;
            end
        end else if (accept) begin
            bank_q[~bank_sel_q][cnt_q] <= pm_new;
        end
    end

    assign acs.ready_o          = ready;
    assign acs.state_x_o        = cnt_q;
    assign acs.decision_o       = dec_q;
    assign acs.decision_state_o = dec_state_q;
    assign acs.decision_valid_o = dec_valid_q;
    assign acs.step_done_o      = step_done_q;
    assign acs.best_state_o     = best_q;

endmodule

// File: tb/tb_acs_unit.sv
// Scoreboard bench for acs_unit: a behavioural trellis model queues expected
// decisions and best states; each cycle the DUT outputs are popped and compared.
module tb_acs_unit;
    localparam int WBM  = 9;
    localparam int WPM  = 12;
    localparam int PMI  = -(2 ** (WPM - 2));
    localparam int SMAX = (2 ** (WPM - 1)) - 1;
    localparam int SMIN = -(2 ** (WPM - 1));

    logic       clk = 1'b0;
    logic       rst_an = 1'b1;
    logic       rst_sync = 1'b0;
    logic       frame_start = 1'b0;
    logic [1:0] reg_num = 2'd0;

    acs_unit_if #(.WIDTH_BM(WBM)) bus ();

    acs_unit #(
        .WIDTH_BM (WBM),
        .WIDTH_PM (WPM)
    ) dut (
        .clk_i          (clk),
        .rst_an_i       (rst_an),
        .rst_sync_i     (rst_sync),
        .frame_start_i  (frame_start),
        .register_num_i (reg_num),
        .acs            (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int dec;
    } dec_t;

    dec_t dec_q[$];
    int   best_q[$];
    int   errors = 0;
    int   checks = 0;

    // Model: 0 = IDLE, 1 = INIT, 2 = RUN
    int m_state;
    int m_pm [2][64];
    int m_sel, m_off, m_max, m_arg, m_n, m_cnt;

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_off   = 0;
        dec_q.delete();
        best_q.delete();
    endtask

    task automatic model_init();
        for (int i = 0; i < 64; i++) m_pm[0][i] = (i == 0) ? 0 : PMI;
        m_sel = 0;
        m_off = 0;
        m_cnt = 0;
        m_max = 0;
        m_arg = 0;
        m_n   = 64 >> reg_num;
    endtask

    task automatic model_acs(input int bm, output bit done);
        int x, plo, phi, clo, chi, d, nv;
        x   = m_cnt;
        plo = x >> 1;
        phi = plo + m_n / 2;
        clo = m_pm[m_sel][plo] + bm;
        chi = m_pm[m_sel][phi] - bm;
        d   = (chi > clo) ? 1 : 0;
        nv  = ((d == 1) ? chi : clo) - m_off;
        if (nv > SMAX) nv = SMAX;
        else if (nv < SMIN) nv = SMIN;
        m_pm[1 - m_sel][x] = nv;
        if (x == 0 || nv > m_max) begin
            m_max = nv;
            m_arg = x;
        end
        dec_q.push_back('{x, d});
        done = 1'b0;
        if (x == m_n - 1) begin
            m_off = m_max;
            m_sel = 1 - m_sel;
            m_cnt = 0;
            best_q.push_back(m_arg);
            done = 1'b1;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    // Drive one clock of stimulus (called at posedge+1) and check outputs after the edge.
    task automatic cycle(input bit valid, input int bm, input bit fs, input bit rs);
        bit   exp_dv, exp_sd;
        dec_t d;
        int   b;
        exp_dv = 1'b0;
        exp_sd = 1'b0;
        bus.bm_valid_i = valid;
        bus.bm_i       = WBM'(bm);
        frame_start    = fs;
        rst_sync       = rs;
        if (rs) begin
            model_reset();
        end else if (fs) begin
            m_state = 1;
            m_cnt   = 0;
        end else if (m_state == 1) begin
            model_init();
            m_state = 2;
        end else if (m_state == 2 && valid) begin
            model_acs(bm, exp_sd);
            exp_dv = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.decision_valid_o !== exp_dv) begin
            errors++;
            $display("FAIL dec_valid t=%0t: got %0b want %0b", $time, bus.decision_valid_o, exp_dv);
        end
        if (exp_dv) begin
            d = dec_q.pop_front();
            checks++;
            if (bus.decision_state_o !== 6'(d.st)) begin
                errors++;
                $display("FAIL dec_state t=%0t: got %0d want %0d", $time, bus.decision_state_o, d.st);
            end
            checks++;
            if (bus.decision_o !== 1'(d.dec)) begin
                errors++;
                $display("FAIL decision x=%0d t=%0t: got %0b want %0d", d.st, $time, bus.decision_o, d.dec);
            end
        end
        checks++;
        if (bus.step_done_o !== exp_sd) begin
            errors++;
            $display("FAIL step_done t=%0t: got %0b want %0b", $time, bus.step_done_o, exp_sd);
        end
        if (exp_sd) begin
            b = best_q.pop_front();
            checks++;
            if (bus.best_state_o !== 6'(b)) begin
                errors++;
                $display("FAIL best_state t=%0t: got %0d want %0d", $time, bus.best_state_o, b);
            end
        end
        checks++;
        if (bus.ready_o !== (m_state == 2)) begin
            errors++;
            $display("FAIL ready t=%0t: got %0b want %0b", $time, bus.ready_o, (m_state == 2));
        end
        checks++;
        if (bus.state_x_o !== 6'(m_cnt)) begin
            errors++;
            $display("FAIL state_x t=%0t: got %0d want %0d", $time, bus.state_x_o, m_cnt);
        end
    endtask

    task automatic start_frame(input logic [1:0] rn);
        reg_num = rn;
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b1, 3, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        logic [21:0] outs;
        outs = {bus.ready_o, bus.state_x_o, bus.decision_o, bus.decision_state_o,
                bus.decision_valid_o, bus.step_done_o, bus.best_state_o};
        checks++;
        if (outs !== 22'd0) begin
            errors++;
            $display("FAIL %s outputs: got %h want 000000", tag, outs);
        end
    endtask

    task automatic test_reset();
        #1 rst_an = 1'b0;
        #2 check_all_zero("por");
        #20 rst_an = 1'b1;
        @(posedge clk);
        #1;
        start_frame(2'd3);
        repeat (3) cycle(1'b1, 10, 1'b0, 1'b0);
        rst_an = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        #2 rst_an = 1'b1;
        repeat (4) cycle(1'b1, 10, 1'b0, 1'b0);
    endtask

    task automatic test_first_step();
        start_frame(2'd3);
        repeat (8) cycle(1'b1, 10, 1'b0, 1'b0);
    endtask

    task automatic test_tie_high();
        start_frame(2'd3);
        repeat (32) cycle(1'b1, 0, 1'b0, 1'b0);
        repeat (8) cycle(1'b1, -5, 1'b0, 1'b0);
    endtask

    task automatic test_norm_sat();
        start_frame(2'd3);
        repeat (800) cycle(1'b1, 48, 1'b0, 1'b0);
        start_frame(2'd3);
        repeat (80) cycle(1'b1, -48, 1'b0, 1'b0);
    endtask

    task automatic test_stall_b2b();
        int acc;
        bit v;
        start_frame(2'd2);
        acc = 0;
        while (acc < 64) begin
            v = 1'($urandom_range(1));
            cycle(v, int'($urandom_range(511)) - 256, 1'b0, 1'b0);
            if (v) acc++;
        end
        start_frame(2'd1);
        repeat (96) cycle(1'b1, int'($urandom_range(511)) - 256, 1'b0, 1'b0);
    endtask

    task automatic test_restart();
        start_frame(2'd0);
        repeat (5) cycle(1'b1, int'($urandom_range(511)) - 256, 1'b0, 1'b0);
        cycle(1'b1, 20, 1'b1, 1'b0);
        cycle(1'b1, 20, 1'b0, 1'b0);
        repeat (67) cycle(1'b1, int'($urandom_range(511)) - 256, 1'b0, 1'b0);
        cycle(1'b1, 0, 1'b1, 1'b1);
        repeat (3) cycle(1'b1, 7, 1'b0, 1'b0);
    endtask

    initial begin
        bus.bm_i       = '0;
        bus.bm_valid_i = 1'b0;
        model_reset();
        test_reset();
        test_first_step();
        test_tie_high();
        test_norm_sat();
        test_stall_b2b();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
